// File: rtl/sevenseg_pkg.sv
// Shared constants for the eight-digit seven-segment scanner: digit count,
// slot-state encoding and the active-high hex glyph table (bit 0 = segment a).
package sevenseg_pkg;

    localparam int unsigned NUM_DIGITS = 8;

    typedef enum logic {
        SLOT_BLANK = 1'b0,
        SLOT_ON    = 1'b1
    } slot_state_e;

    // Active-high glyphs for 0..F; segments a..g on bits 0..6.
    localparam logic [6:0] GLYPHS [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex nibble to active-high seven-segment pattern.
module hex_to_7seg
    import sevenseg_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    // Straight table lookup.
    always_comb begin
        o_seg = GLYPHS[i_nibble];
    end

endmodule

// File: rtl/sevenseg_scan.sv
// Eight-digit multiplexed seven-segment driver. Each digit gets a slot of
// top_cnt+1 cycles whose first BLANK_CYCLES keep all anodes off. New digit
// values are staged by load and only become active at a frame boundary.
module sevenseg_scan
    import sevenseg_pkg::*;
#(
    parameter int unsigned CLK_FREQUENCY_HZ       = 50_000_000,
    parameter int unsigned DIGIT_FREQUENCY_HZ     = 1000,
    parameter int unsigned BLANK_CYCLES           = 16,
    parameter int unsigned SIMULATE               = 0,
    parameter int unsigned SIMULATE_FREQUENCY_CNT = 5,
    parameter int unsigned CNTR_WIDTH             = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    output logic                    upd_pending,
    output logic                    upd_done,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic [6:0]              seg_n,
    output logic                    dp_n
);

    localparam int unsigned TOP_CNT = (SIMULATE != 0) ? SIMULATE_FREQUENCY_CNT
                                                      : CLK_FREQUENCY_HZ / DIGIT_FREQUENCY_HZ - 1;
    localparam logic [CNTR_WIDTH-1:0] TOP_CNT_W = CNTR_WIDTH'(TOP_CNT);
    localparam logic [CNTR_WIDTH-1:0] BLANK_W   = CNTR_WIDTH'(BLANK_CYCLES);
    // A blank window longer than the slot keeps the digit dark for good.
    localparam bit          ALWAYS_BLANK = (BLANK_CYCLES > TOP_CNT);
    localparam slot_state_e RST_STATE    = (ALWAYS_BLANK || BLANK_CYCLES > 0) ? SLOT_BLANK
                                                                              : SLOT_ON;

    logic [CNTR_WIDTH-1:0]   r_slot_cnt;
    logic [2:0]              r_index;
    slot_state_e             r_state;
    slot_state_e             w_state_d;
    logic [CNTR_WIDTH-1:0]   w_slot_next;
    logic                    w_slot_last;
    logic                    w_frame_end;

    logic [4*NUM_DIGITS-1:0] r_stg_digits, r_act_digits;
    logic [NUM_DIGITS-1:0]   r_stg_dp, r_act_dp;
    logic [NUM_DIGITS-1:0]   r_stg_blank, r_act_blank;
    logic                    r_upd_pending, r_upd_done;

    logic [3:0]              w_nibble;
    logic [6:0]              w_glyph;
    logic [NUM_DIGITS-1:0]   w_an_d;
    logic [6:0]              w_seg_d;
    logic                    w_dp_d;
    logic [NUM_DIGITS-1:0]   r_an_n;
    logic [6:0]              r_seg_n;
    logic                    r_dp_n;

    assign w_slot_last = (r_slot_cnt == TOP_CNT_W);
    assign w_frame_end = w_slot_last && (r_index == 3'd7);
    assign w_slot_next = w_slot_last ? '0 : r_slot_cnt + CNTR_WIDTH'(1);
    assign w_nibble    = r_act_digits[{r_index, 2'b00} +: 4];

    hex_to_7seg u_hex (
        .i_nibble (w_nibble),
        .o_seg    (w_glyph)
    );

    // Slot counter, digit index and slot-state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot_cnt <= '0;
            r_index    <= 3'd0;
            r_state    <= RST_STATE;
        end else begin
            r_slot_cnt <= w_slot_next;
            r_state    <= w_state_d;
            if (w_slot_last) begin
                r_index <= r_index + 3'd1;
            end
        end
    end

    // Next slot state and the pin values implied by the current slot.
    always_comb begin
        w_state_d = r_state;
        w_an_d    = '1;
        w_seg_d   = 7'h7F;
        w_dp_d    = 1'b1;
        unique case (r_state)
            SLOT_BLANK: ;
            SLOT_ON: begin
                // Segments stay dark whenever the anode is off to avoid ghosting.
                if (!r_act_blank[r_index]) begin
                    w_an_d  = ~(NUM_DIGITS'(1) << r_index);
                    w_seg_d = ~w_glyph;
                    w_dp_d  = ~r_act_dp[r_index];
                end
            end
            default: ;
        endcase
        if (ALWAYS_BLANK || (w_slot_next < BLANK_W)) begin
            w_state_d = SLOT_BLANK;
        end else begin
            w_state_d = SLOT_ON;
        end
    end

    // Staging capture and frame-boundary transfer; load beats the transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stg_digits  <= '0;
            r_stg_dp      <= '0;
            r_stg_blank   <= '1;
            r_act_digits  <= '0;
            r_act_dp      <= '0;
            r_act_blank   <= '1;
            r_upd_pending <= 1'b0;
            r_upd_done    <= 1'b0;
        end else begin
            r_upd_done <= 1'b0;
            if (load) begin
                r_stg_digits  <= digits_in;
                r_stg_dp      <= dp_in;
                r_stg_blank   <= blank_in;
                r_upd_pending <= 1'b1;
            end else if (w_frame_end && r_upd_pending) begin
                r_act_digits  <= r_stg_digits;
                r_act_dp      <= r_stg_dp;
                r_act_blank   <= r_stg_blank;
                r_upd_pending <= 1'b0;
                r_upd_done    <= 1'b1;
            end
        end
    end

    // Registered pins, one cycle behind the slot counter and index.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_an_n  <= '1;
            r_seg_n <= 7'h7F;
            r_dp_n  <= 1'b1;
        end else begin
            r_an_n  <= w_an_d;
            r_seg_n <= w_seg_d;
            r_dp_n  <= w_dp_d;
        end
    end

    assign upd_pending = r_upd_pending;
    assign upd_done    = r_upd_done;
    assign an_n        = r_an_n;
    assign seg_n       = r_seg_n;
    assign dp_n        = r_dp_n;

endmodule

// File: tb/tb_sevenseg_scan.sv
// Bench for sevenseg_scan with 6-cycle slots (2 blank) and a 48-cycle frame.
module tb_sevenseg_scan;

    localparam int unsigned SLOT  = 6;
    localparam int unsigned BLANK = 2;
    localparam int unsigned FRAME = 48;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [31:0] digits_in;
    logic [7:0]  dp_in;
    logic [7:0]  blank_in;
    logic        upd_pending;
    logic        upd_done;
    logic [7:0]  an_n;
    logic [6:0]  seg_n;
    logic        dp_n;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sevenseg_scan #(
        .CLK_FREQUENCY_HZ       (50_000_000),
        .DIGIT_FREQUENCY_HZ     (1000),
        .BLANK_CYCLES           (2),
        .SIMULATE               (1),
        .SIMULATE_FREQUENCY_CNT (5),
        .CNTR_WIDTH             (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .digits_in   (digits_in),
        .dp_in       (dp_in),
        .blank_in    (blank_in),
        .upd_pending (upd_pending),
        .upd_done    (upd_done),
        .an_n        (an_n),
        .seg_n       (seg_n),
        .dp_n        (dp_n)
    );

    // Active-low glyphs written out directly from the segment drawings.
    function automatic logic [6:0] glyph_n(input logic [3:0] h);
        case (h)
            4'h0: glyph_n = 7'h40;  4'h1: glyph_n = 7'h79;
            4'h2: glyph_n = 7'h24;  4'h3: glyph_n = 7'h30;
            4'h4: glyph_n = 7'h19;  4'h5: glyph_n = 7'h12;
            4'h6: glyph_n = 7'h02;  4'h7: glyph_n = 7'h78;
            4'h8: glyph_n = 7'h00;  4'h9: glyph_n = 7'h10;
            4'hA: glyph_n = 7'h08;  4'hB: glyph_n = 7'h03;
            4'hC: glyph_n = 7'h46;  4'hD: glyph_n = 7'h21;
            4'hE: glyph_n = 7'h06;  default: glyph_n = 7'h0E;
        endcase
    endfunction

    // Model: time since reset determines slot position; frames hold values.
    int unsigned m_t = 0;
    bit          m_valid = 1'b0;
    logic [31:0] m_sd, m_ad;
    logic [7:0]  m_sdp, m_adp, m_sbl, m_abl;
    bit          m_pend, m_done;
    logic [7:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;
    int unsigned mm_slot, mm_dig;
    bit          mm_lit;

    always @(posedge clk) begin
        if (rst) begin
            m_t = 0; m_sd = '0; m_ad = '0; m_sdp = '0; m_adp = '0;
            m_sbl = 8'hFF; m_abl = 8'hFF; m_pend = 0; m_done = 0;
            e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1; m_valid = 1'b1;
        end else if (m_valid) begin
            mm_slot = m_t % SLOT;
            mm_dig  = (m_t / SLOT) % 8;
            mm_lit  = (mm_slot >= BLANK) && !m_abl[mm_dig];
            e_an    = mm_lit ? ~(8'h01 << mm_dig) : 8'hFF;
            e_seg   = mm_lit ? glyph_n(m_ad[mm_dig*4 +: 4]) : 7'h7F;
            e_dp    = mm_lit ? ~m_adp[mm_dig] : 1'b1;
            m_done  = 0;
            if (load) begin
                m_sd = digits_in; m_sdp = dp_in; m_sbl = blank_in; m_pend = 1;
            end else if ((m_t % FRAME) == FRAME - 1 && m_pend) begin
                m_ad = m_sd; m_adp = m_sdp; m_abl = m_sbl; m_pend = 0; m_done = 1;
            end
            m_t++;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            tests++;
            if ({an_n, seg_n, dp_n, upd_pending, upd_done} !==
                {e_an, e_seg, e_dp, m_pend, m_done}) begin
                fails++;
                $display("FAIL model t=%0d an_n=%h/%h seg_n=%h/%h dp_n=%b/%b pend=%b/%b done=%b/%b",
                         m_t, an_n, e_an, seg_n, e_seg, dp_n, e_dp, upd_pending, m_pend,
                         upd_done, m_done);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_phase(input int unsigned p);
        int k = 0;
        while ((m_t % FRAME) != p && k < 2 * FRAME) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic wait_done(input string name);
        int k = 0;
        while (upd_done !== 1'b1 && k < 2 * FRAME + 4) begin
            @(negedge clk);
            k++;
        end
        tests++;
        if (upd_done !== 1'b1) begin
            fails++;
            $display("FAIL %s: upd_done got 0 expected 1 within %0d cycles", name, k);
        end
    endtask

    task automatic do_load(input logic [31:0] d, input logic [7:0] dp, input logic [7:0] bl);
        load = 1'b1; digits_in = d; dp_in = dp; blank_in = bl;
        @(negedge clk);
        load = 1'b0;
    endtask

    int         w_on [8];
    logic [6:0] w_seg [8];
    logic       w_dp [8];
    int         w_dark, w_done, w_bad;

    // Observe one full frame of pins, starting at the cycle after upd_done.
    task automatic watch_frame(input logic [7:0] blank_exp);
        logic [7:0] exp_an;
        w_dark = 0; w_done = 0; w_bad = 0;
        for (int d = 0; d < 8; d++) begin
            w_on[d] = 0; w_seg[d] = 7'h7F; w_dp[d] = 1'b1;
        end
        for (int s = 0; s < 48; s++) begin
            @(negedge clk);
            if (upd_done) w_done++;
            exp_an = ((s % 6) < 2 || blank_exp[s / 6]) ? 8'hFF : ~(8'h01 << (s / 6));
            if (an_n !== exp_an) w_bad++;
            if (an_n == 8'hFF) begin
                w_dark++;
            end else begin
                for (int d = 0; d < 8; d++) begin
                    if (an_n[d] == 1'b0) begin
                        w_on[d]++; w_seg[d] = seg_n; w_dp[d] = dp_n;
                    end
                end
            end
        end
    endtask

    int dark_bad;
    int k_wait;
    int n_done;

    initial begin
        rst = 1'b1; load = 1'b0; digits_in = '0; dp_in = '0; blank_in = '0;
        repeat (3) @(negedge clk);
        check("reset_an_n", 32'(an_n), 32'hFF);
        check("reset_seg_n", 32'(seg_n), 32'h7F);
        check("reset_dp_n", 32'(dp_n), 32'h1);
        check("reset_pending", 32'(upd_pending), 32'h0);
        rst = 1'b0;

        // Idle after reset: display stays dark.
        dark_bad = 0;
        repeat (200) begin
            @(negedge clk);
            if (an_n !== 8'hFF || seg_n !== 7'h7F || dp_n !== 1'b1) dark_bad++;
        end
        check("idle_dark_violations", 32'(dark_bad), 32'h0);

        // Basic load and frame scan.
        wait_phase(20);
        do_load(32'h76543210, 8'h01, 8'h00);
        check("load_sets_pending", 32'(upd_pending), 32'h1);
        wait_done("first_update");
        watch_frame(8'h00);
        check("scan_pattern_bad", 32'(w_bad), 32'h0);
        check("scan_dark_cycles", 32'(w_dark), 32'd16);
        check("scan_extra_done", 32'(w_done), 32'h0);
        check("digit0_on_cycles", 32'(w_on[0]), 32'd4);
        check("digit0_seg", 32'(w_seg[0]), 32'h40);
        check("digit0_dp", 32'(w_dp[0]), 32'h0);
        check("digit3_seg", 32'(w_seg[3]), 32'h30);
        check("digit7_seg", 32'(w_seg[7]), 32'h78);
        check("digit7_dp", 32'(w_dp[7]), 32'h1);

        // Two loads in one frame produce one update with the later value.
        wait_phase(5);
        do_load(32'h11111111, 8'h00, 8'h00);
        repeat (9) @(negedge clk);
        do_load(32'h22222222, 8'h00, 8'h00);
        wait_done("double_load");
        watch_frame(8'h00);
        check("double_extra_done", 32'(w_done), 32'h0);
        for (int d = 0; d < 8; d++) begin
            check($sformatf("double_digit%0d_seg", d), 32'(w_seg[d]), 32'h24);
        end

        // Load on the wrap edge defers the transfer a full frame.
        wait_phase(30);
        do_load(32'h01234567, 8'h00, 8'h00);
        wait_phase(47);
        do_load(32'hFEDCBA98, 8'hFF, 8'h00);
        check("wrap_load_pending", 32'(upd_pending), 32'h1);
        check("wrap_load_no_done", 32'(upd_done), 32'h0);
        k_wait = 0;
        while (upd_done !== 1'b1 && k_wait < 2 * FRAME) begin
            @(negedge clk);
            k_wait++;
        end
        check("wrap_load_delay", 32'(k_wait), 32'd48);
        watch_frame(8'h00);
        check("wrap_digit0_seg", 32'(w_seg[0]), 32'h00);
        check("wrap_digit0_dp", 32'(w_dp[0]), 32'h0);
        check("wrap_digit7_seg", 32'(w_seg[7]), 32'h0E);

        // Per-digit blanking.
        wait_phase(10);
        do_load(32'h88888888, 8'h00, 8'h0F);
        wait_done("blank_update");
        watch_frame(8'h0F);
        check("blank_pattern_bad", 32'(w_bad), 32'h0);
        for (int d = 0; d < 4; d++) begin
            check($sformatf("blank_digit%0d_on", d), 32'(w_on[d]), 32'h0);
        end
        for (int d = 4; d < 8; d++) begin
            check($sformatf("lit_digit%0d_on", d), 32'(w_on[d]), 32'd4);
            check($sformatf("lit_digit%0d_seg", d), 32'(w_seg[d]), 32'h00);
        end

        // Reset aborts a pending update.
        wait_phase(10);
        do_load(32'h12345678, 8'h00, 8'h00);
        repeat (5) @(negedge clk);
        check("abort_pending_before", 32'(upd_pending), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_an_n", 32'(an_n), 32'hFF);
        check("abort_pending", 32'(upd_pending), 32'h0);
        n_done = 0;
        dark_bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (upd_done) n_done++;
            if (an_n !== 8'hFF) dark_bad++;
        end
        check("abort_no_done", 32'(n_done), 32'h0);
        check("abort_dark", 32'(dark_bad), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sevenseg_scan.md
SEVENSEG_SCAN -- requirements
Module: sevenseg_scan

Interface
REQ-001 SHALL have parameter CLK_FREQUENCY_HZ, default 50_000_000: input clock frequency.
REQ-002 SHALL have parameter DIGIT_FREQUENCY_HZ, default 1000: digit advance rate.
REQ-003 SHALL have parameter BLANK_CYCLES, default 16: anode-off cycles at the start of each digit slot.
REQ-004 SHALL have parameter SIMULATE, default 0: when 1, the slot length is SIMULATE_FREQUENCY_CNT+1 cycles.
REQ-005 SHALL have parameter SIMULATE_FREQUENCY_CNT, default 5: slot terminal count in simulation.
REQ-006 SHALL have parameter CNTR_WIDTH, default 32: slot counter width.
REQ-007 clk  in  1  single clock; all logic on its rising edge.
REQ-008 rst  in  1  reset, synchronous, active-high.
REQ-009 load  in  1  one-cycle strobe that captures digits_in, dp_in and blank_in.
REQ-010 digits_in  in  32  eight hex nibbles; nibble k drives digit k.
REQ-011 dp_in  in  8  decimal point per digit; 1 means lit.
REQ-012 blank_in  in  8  per-digit blank; 1 means dark.
REQ-013 upd_pending  out  1  staged values are not yet displayed.
REQ-014 upd_done  out  1  one-cycle pulse when staged values become active.
REQ-015 an_n  out  8  digit anodes, active-low.
REQ-016 seg_n  out  7  segments a..g on bits 0..6, active-low.
REQ-017 dp_n  out  1  decimal point, active-low.

Function
REQ-018 top_cnt SHALL equal SIMULATE ? SIMULATE_FREQUENCY_CNT : CLK_FREQUENCY_HZ/DIGIT_FREQUENCY_HZ-1; slot_cnt SHALL count 0..top_cnt and then wrap to 0.
REQ-019 When slot_cnt==top_cnt, digit index SHALL advance, wrapping from 7 to 0.
REQ-020 The FSM SHALL have two states. SLOT_BLANK covers slot_cnt < BLANK_CYCLES. SLOT_ON covers the rest of the slot. SLOT_BLANK SHALL be re-entered at every wrap.
REQ-021 In SLOT_BLANK, an_n SHALL be 8'hFF.
REQ-022 In SLOT_ON, an_n SHALL have only bit [index] low, unless active blank[index]=1, in which case an_n SHALL be 8'hFF.
REQ-023 seg_n and dp_n SHALL decode the active nibble and dp of the current digit using standard hex glyphs: 0→7'b1000000, 8→7'b0000000, F→7'b0001110.
REQ-024 All pin outputs SHALL be registered, with exactly 1 cycle latency from slot_cnt/index to the pins.
REQ-025 load=1 SHALL copy the inputs into staging registers on that edge and set upd_pending=1.
REQ-026 A second load while pending SHALL overwrite staging; only one upd_done SHALL follow.
REQ-027 On the edge where index wraps 7→0 with upd_pending=1 and load=0:
- staging SHALL be copied to the active registers;
- upd_pending SHALL go to 0;
- upd_done SHALL be 1 for the next cycle only.
REQ-028 If load=1 on the wrap edge, load SHALL win: the transfer is deferred to the next frame and upd_pending stays 1.
REQ-029 Active values SHALL change only at a frame boundary, so no frame mixes old and new digits.
REQ-030 If BLANK_CYCLES > top_cnt, the slot SHALL stay entirely blank, with no counter malfunction.

Reset
REQ-031 While rst=1 on an edge, the following SHALL be cleared: slot_cnt=0, index=0, staging and active digits=0, dp=0, upd_pending=0, upd_done=0.
REQ-032 While rst=1, the following SHALL be set: active and staging blank=8'hFF, an_n=8'hFF, seg_n=7'h7F, dp_n=1.
REQ-033 Reset SHALL abort a pending update; the display SHALL stay dark until the first load plus frame boundary.

Structure
REQ-034 Package sevenseg_pkg SHALL hold the 16-entry glyph table, the NUM_DIGITS=8 constant and the slot-state encoding.
REQ-035 Hex decode SHALL be a combinational sub-module hex_to_7seg (4-bit in, 7-bit active-high out); sevenseg_scan owns the inversion and output registers.

Verification
Bench settings: SIMULATE=1, SIMULATE_FREQUENCY_CNT=5, BLANK_CYCLES=2 (6-cycle slots, 48-cycle frame).
REQ-036 Release reset with no load → an_n=8'hFF, seg_n=7'h7F and dp_n=1 for 200 cycles.
REQ-037 load with digits_in=32'h76543210, dp_in=8'h01, blank_in=0 → upd_done once at the next wrap. Each later slot SHALL show 2 cycles an_n=FF, then 4 cycles of one low anode. Digit 0 SHALL show seg_n=7'b1000000, dp_n=0; digit 7 SHALL show seg_n=7'b1111000.
REQ-038 Two loads 10 cycles apart (32'h11111111, then 32'h22222222) → one upd_done; the next frame shows all digits "2"; no frame mixes values.
REQ-039 load asserted exactly on the wrap edge → upd_pending stays 1; transfer and upd_done occur 48 cycles later.
REQ-040 blank_in=8'h0F with digits 32'h88888888 → anodes 0-3 never low; anodes 4-7 low in their ON windows with seg_n=7'b0000000.
REQ-041 rst pulsed with upd_pending=1 mid-frame → next edge has an_n=FF, upd_pending=0, and no upd_done until a new load.
